// File: rtl/spi_master_multi.sv
// spi_master_multi: single SPI master shared by CSB_WIDTH devices. Each
// transfer selects its own length (1..MAX_BITS), bit order, CPOL and CPHA
// from a command word written on the system clock.
//
// Ports:
//   clk, rst       system clock; asynchronous active-high reset
//   csrStrobe      one-cycle start pulse (ignored and flagged as overrun while busy)
//   cmd            [5:0] nBits-1, [6] lsbFirst, [7] CPOL, [8] CPHA, [19:16] device
//   txData         write data, right-justified
//   rxData         read data, right-justified, valid while busy=0
//   status         [31] busy, [30] overrun (sticky), [29:24] nBits-1 of last command
//   SPI_CLK        serial clock
//   SPI_CSB        active-low chip selects
//   SPI_LE         per-device latch-enable pulse after CSB rises
//   SPI_SDI        master data out
//   SPI_SDO        device data in
//
// Optional feature: define SPI_LE_EN to add the LATCH state and drive SPI_LE.
// Without it SPI_LE is held at zero and busy falls at HOLD exit.
module spi_master_multi #(
  parameter int CLK_RATE  = 100000000,
  parameter int BIT_RATE  = 12500000,
  parameter int CSB_WIDTH = 9,
  parameter int MAX_BITS  = 32,
  parameter int CS_GUARD  = 1,
  parameter     DEBUG     = "false"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csrStrobe,
  input  logic [31:0]          cmd,
  input  logic [MAX_BITS-1:0]  txData,
  output logic [MAX_BITS-1:0]  rxData,
  output logic [31:0]          status,
  output logic                 SPI_CLK,
  output logic [CSB_WIDTH-1:0] SPI_CSB,
  output logic [CSB_WIDTH-1:0] SPI_LE,
  output logic                 SPI_SDI,
  input  logic                 SPI_SDO
);

  localparam int         HP    = (CLK_RATE + 2*BIT_RATE - 1) / (2*BIT_RATE);
  localparam int         DIV_W = (HP > 1) ? $clog2(HP) : 1;
  localparam logic [6:0] MAXB  = 7'(MAX_BITS);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD
`ifdef SPI_LE_EN
    , LATCH
`endif
  } state_t;

  (* mark_debug = DEBUG *) state_t state;

  logic [DIV_W-1:0]     div;
  logic [7:0]           cnt;
  logic [6:0]           nbits;
  logic [5:0]           nbits_m1;
  logic                 lsb, cpol, cpha, busy, overrun;
  logic [MAX_BITS-1:0]  tx_sr, rx_sr, rx_final, tx_load;
  logic [6:0]           cmd_nbits;
  logic [CSB_WIDTH-1:0] cmd_sel;
  logic                 tick, lead, sample_now, shift_now, last_edge, guard_done;
`ifdef SPI_LE_EN
  logic [CSB_WIDTH-1:0] sel;
`endif

  logic unused_cmd;
  assign unused_cmd = ^{cmd[31:20], cmd[15:9]};

  always_comb begin
    cmd_nbits = {1'b0, cmd[5:0]} + 7'd1;
    if (cmd_nbits > MAXB) cmd_nbits = MAXB;
    tx_load = cmd[6] ? txData : (txData << (MAXB - cmd_nbits));
    cmd_sel = '0;
    for (int unsigned i = 0; i < CSB_WIDTH; i++)
      if (cmd[19:16] == 4'(i)) cmd_sel[i] = 1'b1;
  end

  assign tick       = (div == DIV_W'(HP - 1));
  assign guard_done = (cnt == 8'(CS_GUARD - 1));
  assign last_edge  = (cnt == ({1'b0, nbits} << 1) - 8'd1);
  // cnt counts SCLK edges from 0: even cnt is a leading edge.
  assign lead       = ~cnt[0];
  assign sample_now = lead ^ cpha;
  // With CPHA=1 the first bit is already on SDI from SETUP, so the first
  // leading edge must not advance the shifter.
  assign shift_now  = cpha ? (lead && (cnt != 8'd0)) : ~lead;
  // LSB-first receive fills from the top; realign to the LSBs at the end.
  assign rx_final   = lsb ? (rx_sr >> (MAXB - nbits)) : rx_sr;
  assign status     = {busy, overrun, nbits_m1, 24'h0};

`ifndef SPI_LE_EN
  assign SPI_LE = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div      <= '0;
      cnt      <= '0;
      nbits    <= 7'd1;
      nbits_m1 <= '0;
      lsb      <= 1'b0;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rxData   <= '0;
      SPI_CLK  <= 1'b0;
      SPI_CSB  <= '1;
      SPI_SDI  <= 1'b0;
`ifdef SPI_LE_EN
      SPI_LE   <= '0;
      sel      <= '0;
`endif
    end else begin
      if (state != IDLE) begin
        div <= tick ? '0 : div + 1'b1;
        if (csrStrobe) overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          SPI_CLK <= cpol;
          if (csrStrobe) begin
            nbits    <= cmd_nbits;
            nbits_m1 <= cmd[5:0];
            lsb      <= cmd[6];
            cpol     <= cmd[7];
            cpha     <= cmd[8];
            tx_sr    <= tx_load;
            rx_sr    <= '0;
            SPI_SDI  <= cmd[6] ? tx_load[0] : tx_load[MAX_BITS-1];
            overrun  <= 1'b0;
            busy     <= 1'b1;
            SPI_CLK  <= cmd[7];
            SPI_CSB  <= ~cmd_sel;
`ifdef SPI_LE_EN
            sel      <= cmd_sel;
`endif
            div      <= '0;
            cnt      <= '0;
            state    <= SETUP;
          end
        end
        SETUP: if (tick) begin
          cnt <= guard_done ? 8'd0 : cnt + 8'd1;
          if (guard_done) state <= SHIFT;
        end
        SHIFT: if (tick) begin
          SPI_CLK <= ~SPI_CLK;
          if (sample_now)
            rx_sr <= lsb ? {SPI_SDO, rx_sr[MAX_BITS-1:1]} : {rx_sr[MAX_BITS-2:0], SPI_SDO};
          if (shift_now) begin
            SPI_SDI <= lsb ? tx_sr[1] : tx_sr[MAX_BITS-2];
            tx_sr   <= lsb ? (tx_sr >> 1) : (tx_sr << 1);
          end
          cnt <= last_edge ? 8'd0 : cnt + 8'd1;
          if (last_edge) state <= HOLD;
        end
        HOLD: if (tick) begin
          cnt <= guard_done ? 8'd0 : cnt + 8'd1;
          if (guard_done) begin
            SPI_CSB <= '1;
`ifdef SPI_LE_EN
            SPI_LE  <= sel;
            state   <= LATCH;
`else
            busy    <= 1'b0;
            rxData  <= rx_final;
            state   <= IDLE;
`endif
          end
        end
`ifdef SPI_LE_EN
        // Two half-periods: LE high for the first, quiet for the second.
        LATCH: if (tick) begin
          SPI_LE <= '0;
          if (cnt == 8'd1) begin
            cnt    <= 8'd0;
            busy   <= 1'b0;
            rxData <= rx_final;
            state  <= IDLE;
          end else begin
            cnt <= 8'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
module tb_spi_master_multi;

  localparam int HP = 4;
`ifdef SPI_LE_EN
  localparam int LATCH_CLKS = 2*HP;
`else
  localparam int LATCH_CLKS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        csrStrobe;
  logic [31:0] cmd, txData, rxData, status;
  logic        SPI_CLK;
  logic [8:0]  SPI_CSB, SPI_LE;
  logic        SPI_SDI, SPI_SDO;
  logic        loop_en, dev_sdo;

  assign SPI_SDO = loop_en ? SPI_SDI : dev_sdo;

  always #5 clk = ~clk;

  spi_master_multi #(
    .CLK_RATE(100000000), .BIT_RATE(12500000), .CSB_WIDTH(9),
    .MAX_BITS(32), .CS_GUARD(1), .DEBUG("false")
  ) dut (
    .clk(clk), .rst(rst), .csrStrobe(csrStrobe), .cmd(cmd), .txData(txData),
    .rxData(rxData), .status(status), .SPI_CLK(SPI_CLK), .SPI_CSB(SPI_CSB),
    .SPI_LE(SPI_LE), .SPI_SDI(SPI_SDI), .SPI_SDO(SPI_SDO)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input logic [63:0] pat, input int n, input bit lsb, input int i);
    if (i < 0 || i >= n) return 1'b0;
    return lsb ? pat[i] : pat[n-1-i];
  endfunction

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] tx;
    logic [63:0] pat;      // device response when not looped back
    bit          loop;
    int          inj;      // cycle of a stray strobe while busy (0 = none)
    logic [31:0] exp_rx;
    int          exp_edges;
    int          exp_total;
    logic [8:0]  exp_csb;  // OR of selects seen low during transfer
    bit          exp_first;
    logic [63:0] exp_sdi;  // SDI at sample edges, first bit in MSB position
    bit          exp_idle;
    bit          exp_ovr;
    bit          chk_nf;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bit cpol, cpha, lsb;
    int L, rises, cyc, le_cnt, le_cyc, rise_cyc;
    logic [63:0] sdi_w;
    logic [8:0]  csb_or, le_or;
    logic        prev, first;
    n = int'(v.cmd[5:0]) + 1;
    if (n > 32) n = 32;
    cpol = v.cmd[7]; cpha = v.cmd[8]; lsb = v.cmd[6];
    L = 0; rises = 0; cyc = 0; le_cnt = 0; le_cyc = -1; rise_cyc = -1;
    sdi_w = '0; csb_or = '0; le_or = '0;
    @(negedge clk);
    loop_en = v.loop;
    dev_sdo = cpha ? 1'b0 : pat_bit(v.pat, n, lsb, 0);
    cmd = v.cmd; txData = v.tx; csrStrobe = 1'b1;
    @(negedge clk);
    csrStrobe = 1'b0;
    first = SPI_SDI;
    prev  = SPI_CLK;
    while (status[31] && cyc < 2000) begin
      if (v.inj != 0 && cyc == v.inj) begin
        cmd = 32'h0000_0007; txData = 32'h0000_FFFF; csrStrobe = 1'b1;
      end else begin
        csrStrobe = 1'b0;
      end
      csb_or |= ~SPI_CSB;
      le_or  |= SPI_LE;
      if (SPI_LE != '0) begin
        le_cnt++;
        if (le_cyc < 0) le_cyc = cyc;
      end
      if (SPI_CSB == '1 && csb_or != '0 && rise_cyc < 0) rise_cyc = cyc;
      if (SPI_CLK != prev) begin
        if (SPI_CLK) rises++;
        if (SPI_CLK == (cpol == cpha)) sdi_w = {sdi_w[62:0], SPI_SDI};
        else begin
          L++;
          dev_sdo = pat_bit(v.pat, n, lsb, cpha ? L - 1 : L);
        end
        prev = SPI_CLK;
      end
      cyc++;
      @(negedge clk);
    end
    csrStrobe = 1'b0;
    check($sformatf("v%0d busy_drop", idx), status[31], 0);
    check($sformatf("v%0d rxData", idx), rxData, v.exp_rx);
    check($sformatf("v%0d sclk_cycles", idx), rises, v.exp_edges);
    check($sformatf("v%0d total_clks", idx), cyc + 1, v.exp_total + LATCH_CLKS);
    check($sformatf("v%0d csb_seen", idx), csb_or, v.exp_csb);
    check($sformatf("v%0d first_sdi", idx), first, v.exp_first);
    check($sformatf("v%0d sdi_seq", idx), sdi_w, v.exp_sdi);
    check($sformatf("v%0d sclk_idle", idx), SPI_CLK, v.exp_idle);
    check($sformatf("v%0d csb_after", idx), SPI_CSB, 9'h1FF);
    check($sformatf("v%0d status_flags", idx), {status[31:30], status[23:0]}, {1'b0, v.exp_ovr, 24'h0});
    if (v.chk_nf) check($sformatf("v%0d status_nbits", idx), status[29:24], v.cmd[5:0]);
`ifdef SPI_LE_EN
    check($sformatf("v%0d le_seen", idx), le_or, v.exp_csb);
    check($sformatf("v%0d le_len", idx), le_cnt, (v.exp_csb != '0) ? HP : 0);
    if (v.exp_csb != '0) check($sformatf("v%0d le_start", idx), le_cyc, rise_cyc);
`else
    check($sformatf("v%0d le_seen", idx), le_or, 9'h000);
`endif
    check($sformatf("v%0d le_after", idx), SPI_LE, 9'h000);
  endtask

  initial begin
    //           cmd           tx            pat           lp inj rx            ed  tot  csb    f  sdi           idl ov nf
    vecs[0] = '{32'h0003000F, 32'h0000A55A, 64'h0,        1, 0, 32'h0000A55A, 16, 137, 9'h008, 1, 64'hA55A,     0, 0, 1};
    vecs[1] = '{32'h0003000F, 32'h0000A55A, 64'h0,        1, 9, 32'h0000A55A, 16, 137, 9'h008, 1, 64'hA55A,     0, 1, 1};
    vecs[2] = '{32'h000001D7, 32'h00123456, 64'hABCDEF,   0, 0, 32'h00ABCDEF, 24, 201, 9'h001, 0, 64'h6A2C48,   1, 0, 1};
    vecs[3] = '{32'h00080000, 32'h00000001, 64'h0,        1, 0, 32'h00000001,  1,  17, 9'h100, 1, 64'h1,        0, 0, 1};
    vecs[4] = '{32'h0001011F, 32'hDEADBEEF, 64'h13579BDF, 0, 0, 32'h13579BDF, 32, 265, 9'h002, 1, 64'hDEADBEEF, 0, 0, 1};
    vecs[5] = '{32'h000C00C7, 32'h0000003C, 64'hA5,       0, 0, 32'h000000A5,  8,  73, 9'h000, 0, 64'h3C,       1, 0, 1};
    vecs[6] = '{32'h00020028, 32'h89ABCDEF, 64'h0,        1, 0, 32'h89ABCDEF, 32, 265, 9'h004, 1, 64'h89ABCDEF, 0, 0, 0};
    vecs[7] = '{32'h0005000F, 32'h00000F0F, 64'h0,        1, 0, 32'h00000F0F, 16, 137, 9'h020, 0, 64'h0F0F,     0, 0, 1};

    rst = 1'b0; csrStrobe = 1'b0; cmd = '0; txData = '0; loop_en = 1'b1; dev_sdo = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset csb", SPI_CSB, 9'h1FF);
    check("reset sclk", SPI_CLK, 0);
    check("reset sdi", SPI_SDI, 0);
    check("reset le", SPI_LE, 9'h000);
    check("reset status", status, 32'h0);
    check("reset rxData", rxData, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a mode-3 transfer with overrun already set.
    @(negedge clk);
    cmd = 32'h000001D7; txData = 32'h00123456; csrStrobe = 1'b1;
    @(negedge clk);
    csrStrobe = 1'b0;
    repeat (8) @(negedge clk);
    csrStrobe = 1'b1;
    @(negedge clk);
    csrStrobe = 1'b0;
    repeat (10) @(negedge clk);
    check("midshift csb low", SPI_CSB[0], 0);
    check("midshift overrun", status[30], 1);
    #2 rst = 1'b1;
    #1;
    check("async csb", SPI_CSB, 9'h1FF);
    check("async sclk", SPI_CLK, 0);
    check("async busy", status[31], 0);
    check("async overrun", status[30], 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
